// File: rtl/lcd_strobe_pio_pkg.sv
// Shared constants for lcd_strobe_pio: register map, status bit positions, sequencer states.
// Pure declarations with no latency and no flow control.
package lcd_strobe_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_TIMING  = 3'd1;
  localparam logic [2:0] ADDR_SETUP   = 3'd2;
  localparam logic [2:0] ADDR_CTRL    = 3'd3;
  localparam logic [2:0] ADDR_SET     = 3'd4;
  localparam logic [2:0] ADDR_CLEAR   = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE  = 3'd6;
  localparam logic [2:0] ADDR_WSTROBE = 3'd7;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_ERR    = 2;
  localparam int ST_IRQ_EN = 3;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

endpackage

// File: rtl/lcd_strobe_pio_pulse_timer.sv
// Loadable CNT_W down-counter shared by all sequencer states; zero flags the last cycle of a state.
// Load takes effect on the next edge; the counter saturates at zero and never stalls.
module pio_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_strobe_pio.sv
// Avalon-MM parallel output port with a hardware-timed setup/strobe/hold sequencer.
// Zero-wait-state reads, writes take effect next cycle; no backpressure, writes hitting a busy port are dropped and flag err.
module lcd_strobe_pio
  import lcd_strobe_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 16,
  parameter int RST_SETUP = 2,
  parameter int RST_PULSE = 25,
  parameter int RST_HOLD  = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             strobe,
  output logic             busy,
  output logic             irq
);

  logic             wr, ctrl_wr, data_wr, start_req, idle;
  logic             done, err, irq_en, done_set, err_set;
  logic [WIDTH-1:0] data, wd;
  logic [CNT_W-1:0] setup_cnt, pulse_cnt, hold_cnt, pulse_len, tmr_val;
  logic             tmr_load, tmr_zero;
  logic             unused_wd;
  state_t           state, nxt_state;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign idle      = (state == IDLE);
  assign ctrl_wr   = wr & (address == ADDR_CTRL);
  // Addresses 0 and 4..7 all modify the data register.
  assign data_wr   = wr & ((address == ADDR_DATA) | address[2]);
  assign start_req = (ctrl_wr & writedata[0]) | (wr & (address == ADDR_WSTROBE));
  assign pulse_len = (pulse_cnt == '0) ? CNT_W'(1) : pulse_cnt;
  assign done_set  = ~idle & (nxt_state == IDLE);
  assign err_set   = ~idle & (data_wr | start_req);
  assign unused_wd = ^writedata;

  pio_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  // Each state loads its own length minus one on entry, so timing writes while busy hit the next state.
  always_comb begin
    nxt_state = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      IDLE: if (start_req) begin
        tmr_load = 1'b1;
        if (setup_cnt != '0) begin
          nxt_state = SETUP;
          tmr_val   = setup_cnt - CNT_W'(1);
        end else begin
          nxt_state = PULSE;
          tmr_val   = pulse_len - CNT_W'(1);
        end
      end
      SETUP: if (tmr_zero) begin
        nxt_state = PULSE;
        tmr_load  = 1'b1;
        tmr_val   = pulse_len - CNT_W'(1);
      end
      PULSE: if (tmr_zero) begin
        if (hold_cnt != '0) begin
          nxt_state = HOLD;
          tmr_load  = 1'b1;
          tmr_val   = hold_cnt - CNT_W'(1);
        end else begin
          nxt_state = IDLE;
        end
      end
      HOLD: if (tmr_zero) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      strobe    <= 1'b0;
      data      <= '0;
      setup_cnt <= CNT_W'(RST_SETUP);
      pulse_cnt <= CNT_W'(RST_PULSE);
      hold_cnt  <= CNT_W'(RST_HOLD);
      done      <= 1'b0;
      err       <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      state  <= nxt_state;
      busy   <= (nxt_state != IDLE);
      strobe <= (nxt_state == PULSE);
      if (data_wr & idle) begin
        case (address)
          ADDR_SET:    data <= data | wd;
          ADDR_CLEAR:  data <= data & ~wd;
          ADDR_TOGGLE: data <= data ^ wd;
          default:     data <= wd;
        endcase
      end
      if (wr & (address == ADDR_TIMING)) begin
        pulse_cnt <= writedata[CNT_W-1:0];
        hold_cnt  <= writedata[16 +: CNT_W];
      end
      if (wr & (address == ADDR_SETUP)) setup_cnt <= writedata[CNT_W-1:0];
      if (ctrl_wr) irq_en <= writedata[ST_IRQ_EN];
      // Set beats a same-cycle write-one-to-clear.
      done <= done_set | (done & ~(ctrl_wr & writedata[ST_DONE]));
      err  <= err_set | (err & ~(ctrl_wr & writedata[ST_ERR]));
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data;
      ADDR_TIMING: begin
        readdata[CNT_W-1:0]  = pulse_cnt;
        readdata[16 +: CNT_W] = hold_cnt;
      end
      ADDR_SETUP:  readdata[CNT_W-1:0] = setup_cnt;
      ADDR_CTRL: begin
        readdata[ST_BUSY]   = busy;
        readdata[ST_DONE]   = done;
        readdata[ST_ERR]    = err;
        readdata[ST_IRQ_EN] = irq_en;
      end
      default: readdata = '0;
    endcase
  end

  assign out_port = data;
  assign irq      = done & irq_en;

endmodule
